// File: rtl/mmio_store_pkg.sv
// mmio_store_pkg: shared entry type and default MMIO window for the store buffer.
package mmio_store_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;
    localparam logic [31:0] MMIO_BASE  = 32'h60;
    localparam logic [31:0] MMIO_BYTES = 32'h20;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with registered head, zero while empty.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  T                           din,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    T              mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic          do_pop, do_push;
    always_comb begin
        do_pop  = pop & !empty;
        do_push = push & (!full | do_pop);
        full    = count == CW'(DEPTH);
        empty   = count == '0;
        head    = empty ? '0 : mem[rd];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr + AW'(1);
            end
            if (do_pop) rd <= rd + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mmio_store_buffer.sv
// mmio_store_buffer: captures core stores inside the MMIO window and drains them
// in order over valid/ready, with sticky overflow/misalign flags and a drop counter.
module mmio_store_buffer
    import mmio_store_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] BASE_ADDR    = MMIO_BASE,
    parameter logic [31:0] WINDOW_BYTES = MMIO_BYTES,
    parameter int          DROP_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_write,
    input  logic [31:0]                data_adr,
    input  logic [31:0]                write_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       misalign,
    input  logic                       clr_flags,
    output logic [DROP_W-1:0]          drop_count
);
    store_entry_t head;
    logic         in_win, aligned, pop, push, drop, mis;
    always_comb begin
        // unsigned wrap makes addresses below BASE_ADDR fall outside the window
        in_win    = mem_write & ((data_adr - BASE_ADDR) < WINDOW_BYTES);
        aligned   = data_adr[1:0] == 2'b00;
        out_valid = !empty;
        pop       = out_valid & out_ready;
        push      = in_win & aligned & (!full | pop);
        drop      = in_win & aligned & full & !pop;
        mis       = in_win & !aligned;
        out_addr  = head.addr;
        out_data  = head.data;
    end
    sync_fifo #(.DEPTH(DEPTH), .T(store_entry_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ('{addr: data_adr, data: write_data}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            misalign   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop | (overflow & !clr_flags);
            misalign <= mis | (misalign & !clr_flags);
            if (drop && !(&drop_count)) drop_count <= drop_count + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_mmio_store_buffer.sv
// tb_mmio_store_buffer: directed stimulus with hand-computed expectations.
module tb_mmio_store_buffer;
    logic        clk = 0, reset = 0, mem_write = 0, out_ready = 0, clr_flags = 0;
    logic [31:0] data_adr = 0, write_data = 0;
    logic        out_valid, full, empty, overflow, misalign;
    logic [31:0] out_addr, out_data;
    logic [2:0]  count;
    logic [15:0] drop_count;
    int          passed = 0, total = 0;

    mmio_store_buffer dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .count(count), .full(full),
        .empty(empty), .overflow(overflow), .misalign(misalign),
        .clr_flags(clr_flags), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1; data_adr = a; write_data = d;
        step();
        mem_write = 0;
    endtask

    initial begin
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_count, 0);
        #9 reset = 1;
        // basic store and single pop
        st(100, 7);
        chk("t1_valid", out_valid, 1);
        chk("t1_addr", out_addr, 100);
        chk("t1_data", out_data, 7);
        chk("t1_count", count, 1);
        out_ready = 1; step(); out_ready = 0;
        chk("t1_empty", empty, 1);
        chk("t1_zero_data", out_data, 0);
        // window edges
        st(32'h5C, 1); st(32'h80, 2); st(32'h200, 3);
        chk("t2_count", count, 0);
        chk("t2_ovf", overflow, 0);
        chk("t2_mis", misalign, 0);
        st(32'h60, 10); st(32'h7C, 11);
        chk("t2_count2", count, 2);
        chk("t2_addr0", out_addr, 32'h60);
        chk("t2_data0", out_data, 10);
        out_ready = 1; step();
        chk("t2_addr1", out_addr, 32'h7C);
        chk("t2_data1", out_data, 11);
        step(); out_ready = 0;
        chk("t2_empty", empty, 1);
        // overflow
        for (int i = 0; i < 5; i++) st(32'h60 + 4 * i, i + 1);
        chk("t3_full", full, 1);
        chk("t3_count", count, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_count, 1);
        step();
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_data", out_data, 1);
        chk("t3_hold_addr", out_addr, 32'h60);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain", out_data, i + 1);
            step();
        end
        out_ready = 0;
        chk("t3_empty", empty, 1);
        clr_flags = 1; step(); clr_flags = 0;
        chk("t3_ovf_clr", overflow, 0);
        chk("t3_drop_kept", drop_count, 1);
        // push and pop together while full
        for (int i = 0; i < 4; i++) st(32'h60 + 4 * i, i + 1);
        chk("t4_full", full, 1);
        out_ready = 1;
        st(32'h64, 9);
        chk("t4_count", count, 4);
        chk("t4_ovf", overflow, 0);
        chk("t4_drop", drop_count, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", out_data, (i == 3) ? 9 : i + 2);
            step();
        end
        out_ready = 0;
        chk("t4_empty", empty, 1);
        // misalignment
        st(32'h62, 5);
        chk("t5_mis", misalign, 1);
        chk("t5_count", count, 0);
        chk("t5_drop", drop_count, 1);
        clr_flags = 1; step(); clr_flags = 0;
        chk("t5_mis_clr", misalign, 0);
        clr_flags = 1; st(32'h61, 5); clr_flags = 0;
        chk("t5_set_wins", misalign, 1);
        // asynchronous reset mid-queue
        st(32'h60, 1); st(32'h64, 2); st(32'h68, 3);
        chk("t6_count", count, 3);
        #2 reset = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count0", count, 0);
        chk("t6_addr", out_addr, 0);
        chk("t6_data", out_data, 0);
        chk("t6_empty", empty, 1);
        chk("t6_mis", misalign, 0);
        chk("t6_drop", drop_count, 0);
        #1 reset = 1;
        st(100, 7);
        chk("t6_valid2", out_valid, 1);
        chk("t6_addr2", out_addr, 100);
        chk("t6_data2", out_data, 7);
        chk("t6_count2", count, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
